// File: rtl/dis_wei.sv
// dis_wei: unpacks a compressed weight stream (flag beat + packed non-zero
// weight beats per kernel position) into one compacted weight block that is
// held for the PE array until it is captured.
module dis_wei #(
    parameter int DATA_WIDTH  = 8,
    parameter int BLOCK_DEPTH = 32,
    parameter int KERNEL_SIZE = 9
) (
    input  logic                                       clk,
    input  logic                                       rst_n,
    input  logic [BLOCK_DEPTH-1:0]                     GBWEI_Dat,
    input  logic                                       GBWEI_Val,
    output logic                                       DISWEIGB_Rdy,
    output logic                                       CTRLWEIPEC_RdyWei,
    input  logic                                       PECCTRLWEI_GetWei,
    output logic [DATA_WIDTH*BLOCK_DEPTH*KERNEL_SIZE-1:0] DISWEIPEC_Wei,
    output logic [BLOCK_DEPTH*KERNEL_SIZE-1:0]         DISWEIPEC_FlgWei,
    output logic [$clog2(BLOCK_DEPTH)*KERNEL_SIZE-1:0] DISWEIPEC_ValNumWei,
    output logic                                       DISWEI_ErrFmt
);
    localparam int L    = BLOCK_DEPTH / DATA_WIDTH;      // weights per beat
    localparam int VW   = $clog2(BLOCK_DEPTH);           // ValNum field width
    localparam int RW   = VW + 1;                        // holds a full popcount
    localparam int NB   = BLOCK_DEPTH * KERNEL_SIZE;     // weight bytes per block
    localparam int PTRW = $clog2(NB + 1);
    localparam int KW   = (KERNEL_SIZE > 1) ? $clog2(KERNEL_SIZE) : 1;
    localparam logic [KW-1:0] KLAST = KW'(KERNEL_SIZE - 1);

    typedef enum logic [1:0] {FLG, WEI, HOLD} state_e;

    state_e                   state_q, state_d;
    logic [KW-1:0]            k_q, k_d;
    logic [PTRW-1:0]          ptr_q, ptr_d;
    logic [RW-1:0]            rem_q, rem_d;
    logic [DATA_WIDTH*NB-1:0] wei_q, wei_d;
    logic [NB-1:0]            flg_q, flg_d;
    logic [VW*KERNEL_SIZE-1:0] vn_q, vn_d;
    logic                     err_q, err_d;

    logic          fire;
    logic [RW-1:0] pc, take, rem_left;

    function automatic logic [RW-1:0] popcnt(input logic [BLOCK_DEPTH-1:0] v);
        logic [RW-1:0] c;
        c = '0;
        for (int i = 0; i < BLOCK_DEPTH; i++) c = c + RW'(v[i]);
        return c;
    endfunction

    assign fire     = GBWEI_Val && DISWEIGB_Rdy;
    assign pc       = popcnt(GBWEI_Dat);
    // A beat carries at most L weights; the last beat of a kernel may be padded.
    assign take     = (rem_q > RW'(L)) ? RW'(L) : rem_q;
    assign rem_left = rem_q - take;

    // State and datapath registers; reset discards any partial block.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FLG;
            k_q     <= '0;
            ptr_q   <= '0;
            rem_q   <= '0;
            wei_q   <= '0;
            flg_q   <= '0;
            vn_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            ptr_q   <= ptr_d;
            rem_q   <= rem_d;
            wei_q   <= wei_d;
            flg_q   <= flg_d;
            vn_q    <= vn_d;
            err_q   <= err_d;
        end
    end

    // Next-state: walk flag/weight beats per kernel, park in HOLD until captured.
    always_comb begin
        state_d = state_q;
        case (state_q)
            FLG:  if (fire) begin
                      if (pc != '0)         state_d = WEI;
                      else if (k_q == KLAST) state_d = HOLD;
                  end
            WEI:  if (fire && rem_left == '0) state_d = (k_q == KLAST) ? HOLD : FLG;
            HOLD: if (PECCTRLWEI_GetWei) state_d = FLG;
            default: state_d = FLG;
        endcase
    end

    // Datapath next values: store flags/counts, compact weights at ptr.
    always_comb begin
        k_d   = k_q;
        ptr_d = ptr_q;
        rem_d = rem_q;
        wei_d = wei_q;
        flg_d = flg_q;
        vn_d  = vn_q;
        err_d = err_q;
        case (state_q)
            FLG: if (fire) begin
                flg_d[BLOCK_DEPTH*k_q +: BLOCK_DEPTH] = GBWEI_Dat;
                // A full flag word does not fit the count field; it wraps to 0
                // and is flagged, but its weights are still consumed below.
                vn_d[VW*k_q +: VW] = pc[VW-1:0];
                if (pc == RW'(BLOCK_DEPTH)) err_d = 1'b1;
                if (pc != '0)          rem_d = pc;
                else if (k_q != KLAST) k_d = k_q + KW'(1);
            end
            WEI: if (fire) begin
                for (int j = 0; j < L; j++) begin
                    if (j < int'(take))
                        wei_d[DATA_WIDTH*(int'(ptr_q) + j) +: DATA_WIDTH] =
                            GBWEI_Dat[DATA_WIDTH*j +: DATA_WIDTH];
                end
                ptr_d = ptr_q + PTRW'(take);
                rem_d = rem_left;
                if (rem_left == '0 && k_q != KLAST) k_d = k_q + KW'(1);
            end
            HOLD: if (PECCTRLWEI_GetWei) begin
                k_d   = '0;
                ptr_d = '0;
                rem_d = '0;
                wei_d = '0;
                flg_d = '0;
                vn_d  = '0;
            end
            default: ;
        endcase
    end

    // Outputs: handshake levels decoded from state, data straight from registers.
    always_comb begin
        DISWEIGB_Rdy      = (state_q != HOLD);
        CTRLWEIPEC_RdyWei = (state_q == HOLD);
    end

    assign DISWEIPEC_Wei       = wei_q;
    assign DISWEIPEC_FlgWei    = flg_q;
    assign DISWEIPEC_ValNumWei = vn_q;
    assign DISWEI_ErrFmt       = err_q;

endmodule

// File: tb/tb_dis_wei.sv
// tb_dis_wei: directed stream of weight blocks; a reference model builds the
// expected compacted block as beats are sent and a scoreboard checks it in HOLD.
module tb_dis_wei;
    localparam int DW = 8, BD = 32, KS = 9, L = 4, VW = 5;
    localparam int NBY = BD * KS, WW = DW * NBY, FW = BD * KS, NW = VW * KS;

    logic clk = 1'b0, rst_n = 1'b0;
    logic [BD-1:0] GBWEI_Dat = '0;
    logic GBWEI_Val = 1'b0, GetWei = 1'b0;
    logic Rdy, RdyWei, Err;
    logic [WW-1:0] Wei;
    logic [FW-1:0] Flg;
    logic [NW-1:0] Vn;

    dis_wei dut (
        .clk(clk), .rst_n(rst_n),
        .GBWEI_Dat(GBWEI_Dat), .GBWEI_Val(GBWEI_Val),
        .DISWEIGB_Rdy(Rdy), .CTRLWEIPEC_RdyWei(RdyWei),
        .PECCTRLWEI_GetWei(GetWei),
        .DISWEIPEC_Wei(Wei), .DISWEIPEC_FlgWei(Flg),
        .DISWEIPEC_ValNumWei(Vn), .DISWEI_ErrFmt(Err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WW-1:0] wei;
        logic [FW-1:0] flg;
        logic [NW-1:0] vn;
        logic          err;
    } exp_t;

    exp_t sbq[$];
    exp_t cur;
    logic [WW-1:0] m_wei;
    logic [FW-1:0] m_flg;
    logic [NW-1:0] m_vn;
    logic m_err;
    int mk, mptr;
    int nvec = 0, nerr = 0;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp_v);
        nvec++;
        assert (obs === exp_v) else begin
            nerr++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp_v);
        end
    endtask

    task automatic chk_wide(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] exp_v);
        for (int c = 0; c < WW / 256; c++)
            chk($sformatf("%s[%0d]", tag, c), obs[256*c +: 256], exp_v[256*c +: 256]);
    endtask

    task automatic beat(input logic [BD-1:0] d);
        GBWEI_Dat = d;
        GBWEI_Val = 1'b1;
        @(posedge clk);
        #1;
        GBWEI_Val = 1'b0;
        GBWEI_Dat = '0;
    endtask

    task automatic model_clear();
        m_wei = '0; m_flg = '0; m_vn = '0; mk = 0; mptr = 0;
    endtask

    // Send one kernel position: flag, then weights packed L per beat, pad lanes = pad.
    task automatic kern(input logic [31:0] f, input logic [255:0] wb, input logic [7:0] pad);
        int pc;
        logic [31:0] d;
        pc = $countones(f);
        m_flg[BD*mk +: BD] = f;
        m_vn[VW*mk +: VW] = pc[VW-1:0];
        if (pc == BD) m_err = 1'b1;
        for (int i = 0; i < pc; i++) m_wei[DW*(mptr+i) +: DW] = wb[DW*i +: DW];
        mptr += pc;
        mk++;
        beat(f);
        for (int b = 0; b < (pc + L - 1) / L; b++) begin
            for (int j = 0; j < L; j++)
                d[DW*j +: DW] = (b*L + j < pc) ? wb[DW*(b*L+j) +: DW] : pad;
            beat(d);
        end
        if (mk == KS) begin
            sbq.push_back('{m_wei, m_flg, m_vn, m_err});
            model_clear();
        end
    endtask

    task automatic zeros(input int n);
        for (int i = 0; i < n; i++) kern(32'h0, '0, 8'h00);
    endtask

    function automatic logic [255:0] rnd256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom();
        return r;
    endfunction

    task automatic rnd_kerns(input int n);
        for (int i = 0; i < n; i++) kern($urandom() & $urandom(), rnd256(), 8'hEE);
    endtask

    // Called on the cycle after the last beat: the block must already be held.
    task automatic check_block(input string tag);
        chk({tag, "_rdywei"}, RdyWei, 1);
        chk({tag, "_rdy"}, Rdy, 0);
        if (sbq.size() == 0) begin
            nvec++; nerr++;
            $error("FAIL %s_sb: got empty queue want a block", tag);
        end else begin
            cur = sbq.pop_front();
            chk_wide({tag, "_wei"}, Wei, cur.wei);
            chk_wide({tag, "_flg"}, WW'(Flg), WW'(cur.flg));
            chk({tag, "_vn"}, Vn, cur.vn);
            chk({tag, "_err"}, Err, cur.err);
        end
    endtask

    task automatic release_blk(input string tag);
        GetWei = 1'b1;
        @(posedge clk);
        #1;
        GetWei = 1'b0;
        chk({tag, "_rel_rdywei"}, RdyWei, 0);
        chk({tag, "_rel_rdy"}, Rdy, 1);
        chk_wide({tag, "_rel_wei"}, Wei, '0);
        chk_wide({tag, "_rel_flg"}, WW'(Flg), '0);
        chk({tag, "_rel_vn"}, Vn, 0);
    endtask

    task automatic chk_reset(input string tag);
        chk_wide({tag, "_wei"}, Wei, '0);
        chk_wide({tag, "_flg"}, WW'(Flg), '0);
        chk({tag, "_vn"}, Vn, 0);
        chk({tag, "_rdywei"}, RdyWei, 0);
        chk({tag, "_err"}, Err, 0);
    endtask

    initial begin
        model_clear();
        m_err = 1'b0;

        // Reset state
        #12;
        chk_reset("rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_rdy", Rdy, 1);

        // All-zero block
        zeros(9);
        check_block("zero");
        chk("zero_wei_lo", Wei[255:0], '0);
        release_blk("zero");

        // Sparse block, pad lane 0xDD discarded
        kern(32'h7, 256'hCCBBAA, 8'hDD);
        zeros(8);
        check_block("sparse");
        chk("sparse_b0to3", Wei[31:0], 32'h00CCBBAA);
        chk("sparse_vn0", Vn[4:0], 3);
        chk("sparse_err", Err, 0);
        release_blk("sparse");

        // GetWei in FLG ignored
        GetWei = 1'b1;
        @(posedge clk);
        #1;
        GetWei = 1'b0;
        chk("getflg_rdy", Rdy, 1);
        chk("getflg_rdywei", RdyWei, 0);

        // Cross-kernel compaction, with a stray GetWei mid-block
        kern(32'h1F, 256'h0504030201, 8'h00);
        GetWei = 1'b1;
        @(posedge clk);
        #1;
        GetWei = 1'b0;
        kern(32'h1, 256'h09, 8'h00);
        zeros(7);
        check_block("xk");
        chk("xk_b0to5", Wei[47:0], 48'h090504030201);
        chk("xk_vn0", Vn[4:0], 5);
        chk("xk_vn1", Vn[9:5], 1);

        // HOLD ignores valid beats
        GBWEI_Dat = 32'hFFFFFFFF;
        GBWEI_Val = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        GBWEI_Val = 1'b0;
        chk("hold_rdy", Rdy, 0);
        chk("hold_rdywei", RdyWei, 1);
        chk_wide("hold_flg", WW'(Flg), WW'(cur.flg));
        chk_wide("hold_wei", Wei, cur.wei);
        release_blk("xk");

        // Full flag word on the last kernel
        rnd_kerns(8);
        kern(32'hFFFFFFFF, rnd256(), 8'hEE);
        check_block("full");
        chk("full_err", Err, 1);
        chk("full_vn8", Vn[44:40], 0);
        release_blk("full");
        chk("full_err_sticky", Err, 1);

        // Reset in WEI after 2 of 4 beats of k3
        rnd_kerns(3);
        beat(32'h0000FFFF);
        beat(32'h11223344);
        beat(32'h55667788);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset("midrst");
        model_clear();
        m_err = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("midrst_rdy", Rdy, 1);
        rnd_kerns(9);
        check_block("fresh");
        release_blk("fresh");

        // Back-to-back random block
        rnd_kerns(9);
        check_block("rnd");
        release_blk("rnd");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/dis_wei.md
DIS_WEI -- requirements
Module: dis_wei

Interface
REQ-001 Parameter DATA_WIDTH, default 8: bits per weight.
REQ-002 Parameter BLOCK_DEPTH, default 32: channels per kernel position; also the input beat width.
REQ-003 Parameter KERNEL_SIZE, default 9: kernel positions per weight block.
REQ-004 Port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-005 Port rst_n, input, 1: reset, asynchronous and active-low.
REQ-006 Port GBWEI_Dat, input, BLOCK_DEPTH: compressed weight stream beat.
REQ-007 Port GBWEI_Val, input, 1: GBWEI_Dat is valid.
REQ-008 Port DISWEIGB_Rdy, output, 1: this block accepts a beat; a beat transfers when GBWEI_Val and DISWEIGB_Rdy are both high on a clock edge.
REQ-009 Port CTRLWEIPEC_RdyWei, output, 1: level; a complete weight block is held on the outputs.
REQ-010 Port PECCTRLWEI_GetWei, input, 1: one-cycle pulse; the consumer captures the block in this cycle.
REQ-011 Port DISWEIPEC_Wei, output, DATA_WIDTH*BLOCK_DEPTH*KERNEL_SIZE: compacted non-zero weights; byte i at bits [DATA_WIDTH*i +: DATA_WIDTH].
REQ-012 Port DISWEIPEC_FlgWei, output, BLOCK_DEPTH*KERNEL_SIZE: flag word k at bits [BLOCK_DEPTH*k +: BLOCK_DEPTH].
REQ-013 Port DISWEIPEC_ValNumWei, output, C_LOG_2(BLOCK_DEPTH)*KERNEL_SIZE: popcount of flag word k, truncated to field width.
REQ-014 Port DISWEI_ErrFmt, output, 1: sticky format error.

Function
REQ-015 The stream format per block SHALL be, for k = 0..KERNEL_SIZE-1: one flag beat, then ceil(P_k / (BLOCK_DEPTH/DATA_WIDTH)) weight beats, where P_k = popcount(flag k).
REQ-016 FSM states SHALL be FLG (expect flag beat), WEI (expect weight beats) and HOLD (block complete); the reset state is FLG with k=0, ptr=0.
REQ-017 A flag beat in FLG SHALL store the beat as flag k and store P_k as ValNum k.
- If P_k=0 and k<KERNEL_SIZE-1: k+1, stay in FLG.
- If P_k=0 and k=KERNEL_SIZE-1: go to HOLD.
- If P_k>0: go to WEI with rem=P_k.
REQ-018 A weight beat in WEI SHALL write lanes j=0..min(L,rem)-1 (lane j = bits [DATA_WIDTH*j +: DATA_WIDTH], L=BLOCK_DEPTH/DATA_WIDTH) to Wei bytes ptr+j.
- Then ptr += min(L,rem) and rem -= min(L,rem).
- Pad lanes are discarded.
REQ-019 When rem reaches 0, the FSM SHALL go to FLG with k+1, or to HOLD if k=KERNEL_SIZE-1.
REQ-020 DISWEIGB_Rdy SHALL be high in FLG and WEI and low in HOLD.
REQ-021 CTRLWEIPEC_RdyWei SHALL be high exactly in HOLD, asserted the cycle after the last beat is accepted.
REQ-022 GetWei in HOLD SHALL hold all outputs valid in that cycle; on the next edge:
- go to FLG with k=0 and ptr=0;
- clear Wei, FlgWei and ValNumWei to 0;
- CTRLWEIPEC_RdyWei falls.
REQ-023 GetWei outside HOLD SHALL be ignored.
REQ-024 Wei bytes at index >= final ptr SHALL read 0 in HOLD.
REQ-025 A flag word with P_k=BLOCK_DEPTH SHALL set DISWEI_ErrFmt.
- ValNum k stores P_k truncated (0).
- All BLOCK_DEPTH weights are still consumed and written.
REQ-026 ptr SHALL be ceil(log2(BLOCK_DEPTH*KERNEL_SIZE+1)) bits wide and cannot overflow (maximum 288 with the default parameters).
REQ-027 Beats presented while GBWEI_Val is low SHALL have no effect; a transfer can occur every cycle.

Reset
REQ-028 rst_n low SHALL immediately force:
- state FLG, k=0, ptr=0, rem=0;
- all data outputs 0;
- CTRLWEIPEC_RdyWei=0;
- DISWEI_ErrFmt=0;
- DISWEIGB_Rdy=1 after release.
REQ-029 Reset mid-block SHALL discard the partial block; loading restarts from a flag beat for k=0.
REQ-030 DISWEI_ErrFmt SHALL clear only on reset.

Verification
REQ-031 All-zero block: 9 flag beats of 0x00000000 -> RdyWei=1 on the cycle after the 9th beat; FlgWei=0, ValNumWei=0, Wei=0.
REQ-032 Sparse block: k0 flag 0x00000007, then beat 0xDDCCBBAA; others 0 -> ValNum0=3, Wei bytes 0..2 = AA,BB,CC; byte 3=0; ErrFmt=0.
REQ-033 Cross-kernel compaction: k0 flag 0x0000001F with beats 0x04030201 and 0x00000005; k1 flag 0x00000001 with beat 0x00000009 -> Wei bytes 0..5 = 01,02,03,04,05,09; ValNum0=5, ValNum1=1.
REQ-034 Handshake: in HOLD with GBWEI_Val=1, no beat is accepted (Rdy=0); a GetWei pulse -> next cycle outputs are 0, RdyWei=0, Rdy=1; GetWei pulsed in FLG is ignored.
REQ-035 Full flag: k8 flag 0xFFFFFFFF plus 8 beats -> ErrFmt=1, ValNum8=0, Wei bytes ptr..ptr+31 written, RdyWei=1; ErrFmt stays 1 after GetWei.
REQ-036 Reset in WEI after 2 of 4 beats of k3 -> all outputs 0; a fresh 9-kernel block then loads correctly from k=0.
